// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising LFSR pattern checker; locks onto the generator's
// state sequence, then free-runs its own prediction and counts mismatching words.
module lfsr_checker #(
    parameter int SIZE         = 8,
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SIZE-1:0]  tap,
    input  logic             in_valid,
    input  logic [SIZE-1:0]  in_word,
    input  logic             clear_counts,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] word_count
);
    typedef enum logic {HUNT, LOCKED} state_t;

    state_t          state, state_nx;
    logic [SIZE-1:0] ref_word, ref_nx, tap_eff, pred;
    logic            have_ref, have_nx, hit, pulse_nx, err_inc, word_inc;
    logic [7:0]      match_cnt, match_nx, bad_cnt, bad_nx;
    logic [8:0]      match_p1, bad_p1;

    // Bit 0 of the mask is forced on so the feedback bit itself lands in nx[0].
    function automatic logic [SIZE-1:0] nx(input logic [SIZE-1:0] s, input logic [SIZE-1:0] t);
        logic f;
        f = s[SIZE-1] ^ (s[SIZE-2:0] == '0);
        return {s[SIZE-2:0], 1'b0} ^ ({SIZE{f}} & (t | SIZE'(1)));
    endfunction

    assign tap_eff  = (tap == '0 || tap == '1) ? SIZE'(2) : tap;
    assign pred     = nx(ref_word, tap_eff);
    assign hit      = in_word == pred;
    assign match_p1 = {1'b0, match_cnt} + 9'd1;
    assign bad_p1   = {1'b0, bad_cnt} + 9'd1;
    assign locked   = state == LOCKED;

    always_comb begin
        state_nx = state;
        ref_nx   = ref_word;
        have_nx  = have_ref;
        match_nx = match_cnt;
        bad_nx   = bad_cnt;
        pulse_nx = 1'b0;
        err_inc  = 1'b0;
        word_inc = 1'b0;
        if (in_valid && state == HUNT) begin
            match_nx = (have_ref && hit) ? match_p1[7:0] : 8'd0;
            ref_nx   = in_word;
            have_nx  = 1'b1;
            if (have_ref && hit && match_p1 == 9'(LOCK_COUNT)) begin
                state_nx = LOCKED;
                bad_nx   = 8'd0;
            end
        end else if (in_valid) begin
            ref_nx   = pred;
            word_inc = 1'b1;
            bad_nx   = hit ? 8'd0 : bad_p1[7:0];
            pulse_nx = !hit;
            err_inc  = !hit;
            if (!hit && bad_p1 == 9'(UNLOCK_COUNT)) begin
                state_nx = HUNT;
                ref_nx   = in_word;
                match_nx = 8'd0;
                have_nx  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HUNT;
            ref_word   <= '0;
            have_ref   <= 1'b0;
            match_cnt  <= 8'd0;
            bad_cnt    <= 8'd0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
            word_count <= '0;
        end else begin
            state     <= state_nx;
            ref_word  <= ref_nx;
            have_ref  <= have_nx;
            match_cnt <= match_nx;
            bad_cnt   <= bad_nx;
            err_pulse <= pulse_nx;
            if (clear_counts) begin
                err_count  <= '0;
                word_count <= '0;
            end else begin
                if (err_inc && err_count != '1) err_count <= err_count + CNT_W'(1);
                if (word_inc && word_count != '1) word_count <= word_count + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: directed stimulus with a queued expectation scoreboard for lfsr_checker.
module tb_lfsr_checker;
    logic       clk = 1'b0, rst = 1'b1, in_valid = 1'b0, clear_counts = 1'b0;
    logic [7:0] tap = 8'h1D, in_word = 8'h00;
    logic       locked, err_pulse;
    logic [3:0] err_count, word_count;

    typedef struct {
        string      tag;
        logic       l;
        logic       p;
        logic [3:0] e;
        logic [3:0] w;
    } exp_t;

    exp_t       q[$];
    exp_t       cur;
    int         checks = 0, failures = 0;
    logic [7:0] bvec [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00, 8'h1D};
    logic [7:0] dvec [6]  = '{8'h00, 8'h03, 8'h06, 8'h0C, 8'h18, 8'h30};
    logic [7:0] g, h;
    int         e, w;

    lfsr_checker #(.SIZE(8), .LOCK_COUNT(4), .UNLOCK_COUNT(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .tap(tap), .in_valid(in_valid), .in_word(in_word),
        .clear_counts(clear_counts), .locked(locked), .err_pulse(err_pulse),
        .err_count(err_count), .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Generator model used only to produce stimulus words past the hand-listed ones.
    function automatic logic [7:0] gen(input logic [7:0] s, input logic [7:0] t);
        logic [7:0] n;
        logic       f;
        f = s[7] ^ (s[6:0] == 7'd0);
        n[0] = f;
        for (int b = 1; b < 8; b++) n[b] = s[b-1] ^ (t[b] & f);
        return n;
    endfunction

    function automatic int sat(input int v);
        return v > 15 ? 15 : v;
    endfunction

    task automatic step(input logic r, input logic v, input logic c, input logic [7:0] wd,
                        input string tag, input logic el, input logic ep, input int ee, input int ew);
        exp_t x;
        rst = r; in_valid = v; clear_counts = c; in_word = wd;
        @(posedge clk);
        #1;
        x.tag = tag; x.l = el; x.p = ep; x.e = 4'(ee); x.w = 4'(ew);
        q.push_back(x);
        rst = 1'b0; in_valid = 1'b0; clear_counts = 1'b0;
    endtask

    task automatic chk(input string n, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            cur = q.pop_front();
            chk({cur.tag, "/locked"}, int'(locked), int'(cur.l));
            chk({cur.tag, "/err_pulse"}, int'(err_pulse), int'(cur.p));
            chk({cur.tag, "/err_count"}, int'(err_count), int'(cur.e));
            chk({cur.tag, "/word_count"}, int'(word_count), int'(cur.w));
        end
    end

    initial begin
        step(1, 0, 0, 8'h00, "reset", 0, 0, 0, 0);
        step(1, 1, 0, 8'h01, "reset_valid", 0, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            step(0, 1, 0, bvec[i], "lock_seq", i >= 4, 0, 0, i >= 4 ? i - 4 : 0);
        g = 8'h1D;
        g = gen(g, 8'h1D);
        step(0, 1, 0, 8'hFF, "corrupt", 1, 1, 1, 6);
        g = gen(g, 8'h1D);
        step(0, 1, 0, g, "after_corrupt", 1, 0, 1, 7);
        g = gen(g, 8'h1D);
        step(0, 1, 0, g, "after_corrupt2", 1, 0, 1, 8);
        step(0, 0, 1, 8'h00, "clear", 1, 0, 0, 0);
        g = gen(g, 8'h1D);
        step(0, 1, 1, ~g, "clear_on_err", 1, 1, 0, 0);
        g = gen(g, 8'h1D);
        step(0, 1, 0, g, "post_clear", 1, 0, 0, 1);
        e = 0; w = 1;
        for (int i = 0; i < 20; i++) begin
            g = gen(g, 8'h1D);
            e = sat(e + 1); w = sat(w + 1);
            step(0, 1, 0, g ^ 8'h01, "sat_bad", 1, 1, e, w);
            repeat ($urandom_range(0, 2)) step(0, 0, 0, 8'hAA, "gap", 1, 0, e, w);
            g = gen(g, 8'h1D);
            w = sat(w + 1);
            step(0, 1, 0, g, "sat_good", 1, 0, e, w);
        end
        step(0, 0, 1, 8'h00, "clear2", 1, 0, 0, 0);
        h = g;
        repeat (100) h = gen(h, 8'h1D);
        for (int j = 0; j < 4; j++) begin
            h = gen(h, 8'h1D);
            step(0, 1, 0, h, "unlock", j < 3, 1, j + 1, j + 1);
        end
        for (int j = 0; j < 4; j++) begin
            h = gen(h, 8'h1D);
            step(0, 1, 0, h, "relock", j == 3, 0, 4, 4);
        end
        h = gen(h, 8'h1D);
        step(0, 1, 0, h, "relocked_word", 1, 0, 4, 5);
        h = gen(h, 8'h1D);
        step(1, 1, 0, h, "reset_locked", 0, 0, 0, 0);
        for (int j = 0; j < 5; j++) begin
            h = gen(h, 8'h1D);
            step(0, 1, 0, h, "lock_after_reset", j == 4, 0, 0, 0);
        end
        tap = 8'h00;
        step(1, 0, 0, 8'h00, "reset_tap00", 0, 0, 0, 0);
        for (int j = 0; j < 6; j++)
            step(0, 1, 0, dvec[j], "tap00", j >= 4, 0, 0, j >= 4 ? j - 4 : 0);
        tap = 8'hFF;
        step(1, 0, 0, 8'h00, "reset_tapFF", 0, 0, 0, 0);
        for (int j = 0; j < 6; j++)
            step(0, 1, 0, dvec[j], "tapFF", j >= 4, 0, 0, j >= 4 ? j - 4 : 0);
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
